mfp_ahb_gpio_irq: RTL

Parametrised AHB-Lite GPIO slave that replaces the fixed-width GPIO/Rojobot I/O block. It adds 2-flop input synchronisers, sticky edge-capture of pushbuttons and the Rojobot update strobe, and a maskable interrupt line. `IO_INT_ACK` is generated in hardware when software clears the bot-update flag. It sits on the AHB decoder next to the RAM/ROM slaves and drives the board I/O and the Rojobot control port.

---
 rtl/mfp_ahb_gpio_irq_pkg.sv | 15 +
 rtl/mfp_sync_edge.sv | 32 +++
 rtl/mfp_ahb_gpio_irq.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mfp_ahb_gpio_irq_pkg.sv
// rtl/mfp_ahb_gpio_irq_pkg.sv - register indices and bus constants for the GPIO/IRQ slave
package mfp_ahb_gpio_irq_pkg;

  localparam logic [3:0] H_SW_IONUM      = 4'd0;
  localparam logic [3:0] H_PB_IONUM      = 4'd1;
  localparam logic [3:0] H_LED_IONUM     = 4'd2;
  localparam logic [3:0] H_BOTINFO_IONUM = 4'd3;
  localparam logic [3:0] H_BOTCTRL_IONUM = 4'd4;
  localparam logic [3:0] H_STATUS_IONUM  = 4'd5;
  localparam logic [3:0] H_ENABLE_IONUM  = 4'd6;
  localparam logic [3:0] H_BOTUPDT_IONUM = 4'd7;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

endpackage

// File: rtl/mfp_sync_edge.sv
// rtl/mfp_sync_edge.sv - 2-flop synchroniser with rising-edge detect
module mfp_sync_edge #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;

  // Two metastability flops, then a third holding the previous synchronised value
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_q    = r_s2;
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/mfp_ahb_gpio_irq.sv
// rtl/mfp_ahb_gpio_irq.sv - AHB-Lite GPIO slave with sticky edge capture and maskable IRQ
module mfp_ahb_gpio_irq
  import mfp_ahb_gpio_irq_pkg::*;
#(
  parameter int N_SW  = 16,
  parameter int N_PB  = 5,
  parameter int N_LED = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [3:0]       HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic             HSEL,
  input  logic [31:0]      HWDATA,
  output logic [31:0]      HRDATA,
  input  logic [N_SW-1:0]  IO_Switch,
  input  logic [N_PB-1:0]  IO_PB,
  output logic [N_LED-1:0] IO_LED,
  output logic [7:0]       IO_BotCtrl,
  input  logic [31:0]      IO_BotInfo,
  input  logic             IO_BotUpdt_Sync,
  output logic             IO_INT_ACK,
  output logic             IRQ
);

  logic [3:0]    r_haddr_d;
  logic [1:0]    r_htrans_d;
  logic          r_hwrite_d;
  logic          r_hsel_d;
  logic          r_botupdt_q;
  logic [N_PB:0] r_status;
  logic [N_PB:0] r_enable;

  logic [N_SW-1:0] w_sw;
  logic [N_SW-1:0] w_sw_rise;
  logic [N_PB-1:0] w_pb;
  logic [N_PB-1:0] w_pb_rise;
  logic            w_bot_rise;
  logic            w_we;
  logic            w_re;
  logic            w_status_we;
  logic [N_PB:0]   w_clr;
  logic [N_PB:0]   w_set;
  logic [31:0]     w_rdata;

  mfp_sync_edge #(.W(N_SW)) u_sync_sw (
    .i_clk  (HCLK),
    .i_rstn (HRESETn),
    .i_d    (IO_Switch),
    .o_q    (w_sw),
    .o_rise (w_sw_rise)
  );

  mfp_sync_edge #(.W(N_PB)) u_sync_pb (
    .i_clk  (HCLK),
    .i_rstn (HRESETn),
    .i_d    (IO_PB),
    .o_q    (w_pb),
    .o_rise (w_pb_rise)
  );

  assign w_bot_rise  = IO_BotUpdt_Sync & ~r_botupdt_q;
  assign w_we        = (r_htrans_d != HTRANS_IDLE) & r_hsel_d & r_hwrite_d;
  assign w_re        = HSEL & ~HWRITE & (HTRANS != HTRANS_IDLE);
  assign w_status_we = w_we & (r_haddr_d == H_STATUS_IONUM);
  assign w_clr       = w_status_we ? HWDATA[N_PB:0] : '0;
  assign w_set       = {w_pb_rise, w_bot_rise};

  // Read mux on the undelayed address so data is ready in the data phase
  always_comb begin
    w_rdata = '0;
    case (HADDR)
      H_SW_IONUM:      w_rdata = 32'(w_sw);
      H_PB_IONUM:      w_rdata = 32'(w_pb);
      H_LED_IONUM:     w_rdata = 32'(IO_LED);
      H_BOTINFO_IONUM: w_rdata = IO_BotInfo;
      H_BOTCTRL_IONUM: w_rdata = {24'd0, IO_BotCtrl};
      H_STATUS_IONUM:  w_rdata = 32'(r_status);
      H_ENABLE_IONUM:  w_rdata = 32'(r_enable);
      H_BOTUPDT_IONUM: w_rdata = {31'd0, IO_BotUpdt_Sync};
      default:         w_rdata = '0;
    endcase
  end

  // Address-phase pipeline, read data capture and bot-update history
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_haddr_d   <= '0;
      r_htrans_d  <= HTRANS_IDLE;
      r_hwrite_d  <= 1'b0;
      r_hsel_d    <= 1'b0;
      r_botupdt_q <= 1'b0;
      HRDATA      <= '0;
    end else begin
      r_haddr_d   <= HADDR;
      r_htrans_d  <= HTRANS;
      r_hwrite_d  <= HWRITE;
      r_hsel_d    <= HSEL;
      r_botupdt_q <= IO_BotUpdt_Sync;
      if (w_re) HRDATA <= w_rdata;
    end
  end

  // Data-phase register writes; a capture event beats a simultaneous W1C
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      IO_LED     <= '0;
      IO_BotCtrl <= '0;
      r_enable   <= '0;
      r_status   <= '0;
      IO_INT_ACK <= 1'b0;
      IRQ        <= 1'b0;
    end else begin
      if (w_we && r_haddr_d == H_LED_IONUM)     IO_LED     <= HWDATA[N_LED-1:0];
      if (w_we && r_haddr_d == H_BOTCTRL_IONUM) IO_BotCtrl <= HWDATA[7:0];
      if (w_we && r_haddr_d == H_ENABLE_IONUM)  r_enable   <= HWDATA[N_PB:0];
      r_status   <= (r_status & ~w_clr) | w_set;
      // Acknowledge only when a pending bot update is genuinely retired
      IO_INT_ACK <= w_status_we & HWDATA[0] & r_status[0] & ~w_bot_rise;
      IRQ        <= |(r_status & r_enable);
    end
  end

endmodule
